capture_reader: RTL



---
 rtl/capture_pkg.sv | 23 ++
 rtl/capture_reader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: settings shared by the logic-analyser sampler (write side)
// and capture_reader (read side): RAM geometry, the header sync byte and
// the reader state encoding.
package capture_pkg;

    localparam int unsigned CAP_ADDR_W = 17;
    localparam int unsigned CAP_DATA_W = 8;
    localparam int unsigned CAP_DEPTH  = 131072;
    localparam int unsigned LAST_ADDR  = CAP_DEPTH - 1;

    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAP,
        ST_HEADER,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_FINISH
    } cap_state_t;

endpackage

// File: rtl/capture_reader.sv
// capture_reader: once a capture has filled the sample RAM, reads it from
// address 0 to DEPTH-1 and streams each sample on a valid/ready byte port
// toward the host-link transmitter. One byte every 3 cycles at best
// (READ, LATCH, SEND).
// Build option CAPTURE_READER_HEADER_EN: prefix the stream with the three
// bytes 0xA5, DEPTH[15:8], DEPTH[7:0].
module capture_reader
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = CAP_ADDR_W,
    parameter int unsigned DATA_W = CAP_DATA_W,
    parameter int unsigned DEPTH  = CAP_DEPTH
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              capture_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef CAPTURE_READER_HEADER_EN
    localparam logic [31:0] DEPTH_VEC = 32'(DEPTH);
    logic [1:0]        r_hdr_idx;
`endif

    cap_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rd_en;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_hs;
    logic              w_last;

    assign w_hs   = r_tx_valid && tx_ready;
    assign w_last = (r_cnt == LAST_IDX);

    // The counter doubles as the read address; it only changes while rd_en is low.
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_cnt;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

    // Dump sequencer: every output is a register updated on the state transition.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef CAPTURE_READER_HEADER_EN
            r_hdr_idx  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_WAIT_CAP;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_CAP: begin
                    if (capture_done) begin
`ifdef CAPTURE_READER_HEADER_EN
                        r_state    <= ST_HEADER;
                        r_tx_data  <= DATA_W'(HDR_SYNC);
                        r_tx_valid <= 1'b1;
                        r_hdr_idx  <= '0;
`else
                        r_state <= ST_READ;
                        r_rd_en <= 1'b1;
`endif
                    end
                end
`ifdef CAPTURE_READER_HEADER_EN
                ST_HEADER: begin
                    if (w_hs) begin
                        if (r_hdr_idx == 2'd2) begin
                            r_tx_valid <= 1'b0;
                            r_rd_en    <= 1'b1;
                            r_state    <= ST_READ;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                            r_tx_data <= (r_hdr_idx == 2'd0) ? DATA_W'(DEPTH_VEC[15:8])
                                                             : DATA_W'(DEPTH_VEC[7:0]);
                        end
                    end
                end
`endif
                ST_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_tx_data  <= rd_data;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_cnt   <= r_cnt + ADDR_W'(1);
                            r_rd_en <= 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
